// File: rtl/ex_muldiv.sv
// Iterative radix-2 RV32M multiply/divide unit for the EX stage.
// Magnitudes are iterated one bit per clock. The sign is applied once the
// last step completes. Divide-by-zero and signed overflow skip iteration.
module ex_muldiv #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             flush,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic             stall,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

    localparam logic [5:0]       LAST    = 6'(WIDTH - 1);
    localparam logic [WIDTH-1:0] INT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

    state_t               state_reg, state_next;
    logic [5:0]           count_reg, count_next;
    logic [2*WIDTH-1:0]   acc_reg, acc_next;
    logic [WIDTH-1:0]     opnd_reg, opnd_next;
    logic [2:0]           op_reg, op_next;
    logic                 neg_q_reg, neg_q_next;
    logic                 neg_r_reg, neg_r_next;
    logic [WIDTH-1:0]     result_reg, result_next;

    // Operand conditioning on the incoming instruction
    logic                 a_signed, b_signed, a_neg, b_neg;
    logic [WIDTH-1:0]     a_mag, b_mag;
    logic                 div_special;
    logic [WIDTH-1:0]     special_res;

    // Iteration datapath
    logic [WIDTH:0]       mul_sum;
    logic [2*WIDTH-1:0]   mul_acc;
    logic [WIDTH:0]       rem_sh;
    logic                 div_ge;
    logic [WIDTH-1:0]     div_diff;
    logic [2*WIDTH-1:0]   div_acc;
    logic [2*WIDTH-1:0]   step_acc;
    logic [2*WIDTH-1:0]   prod;
    logic [WIDTH-1:0]     quot, rem;
    logic [WIDTH-1:0]     final_res;

    // rs1 is signed for MULH/MULHSU/DIV/REM, rs2 only for MULH/DIV/REM
    assign a_signed = (op == 3'b001) || (op == 3'b010) || (op == 3'b100) || (op == 3'b110);
    assign b_signed = (op == 3'b001) || (op == 3'b100) || (op == 3'b110);
    assign a_neg    = a_signed & src_a[WIDTH-1];
    assign b_neg    = b_signed & src_b[WIDTH-1];
    assign a_mag    = a_neg ? -src_a : src_a;
    assign b_mag    = b_neg ? -src_b : src_b;

    // Zero divisor for any divide op, or signed INT_MIN / -1
    assign div_special = op[2] & ((src_b == '0) |
                         (~op[0] & (src_a == INT_MIN) & (src_b == '1)));
    // op[1] selects remainder; overflow yields INT_MIN quotient, zero remainder
    assign special_res = (src_b == '0) ? (op[1] ? src_a : '1)
                                       : (op[1] ? '0 : INT_MIN);

    // Shift-add: add the multiplicand into the high half when the LSB is set, then shift right
    assign mul_sum = {1'b0, acc_reg[2*WIDTH-1:WIDTH]} + (acc_reg[0] ? {1'b0, opnd_reg} : '0);
    assign mul_acc = {mul_sum, acc_reg[WIDTH-1:1]};

    // Restoring divide: shift partial remainder left, subtract divisor if it fits
    assign rem_sh   = acc_reg[2*WIDTH-1:WIDTH-1];
    assign div_ge   = rem_sh >= {1'b0, opnd_reg};
    assign div_diff = rem_sh[WIDTH-1:0] - opnd_reg;
    assign div_acc  = div_ge ? {div_diff, acc_reg[WIDTH-2:0], 1'b1}
                             : {acc_reg[2*WIDTH-2:0], 1'b0};

    assign step_acc = op_reg[2] ? div_acc : mul_acc;

    // Sign fix-up over the full product so the high half is correct
    assign prod = neg_q_reg ? -step_acc : step_acc;
    assign quot = neg_q_reg ? -step_acc[WIDTH-1:0] : step_acc[WIDTH-1:0];
    assign rem  = neg_r_reg ? -step_acc[2*WIDTH-1:WIDTH] : step_acc[2*WIDTH-1:WIDTH];

    // Select the architectural result from the last step's accumulator
    always_comb begin
        final_res = prod[WIDTH-1:0];
        case (op_reg)
            3'b000:                 final_res = prod[WIDTH-1:0];
            3'b001, 3'b010, 3'b011: final_res = prod[2*WIDTH-1:WIDTH];
            3'b100, 3'b101:         final_res = quot;
            default:                final_res = rem;
        endcase
    end

    // Next-state, datapath updates and handshake outputs
    always_comb begin
        state_next  = state_reg;
        count_next  = count_reg;
        acc_next    = acc_reg;
        opnd_next   = opnd_reg;
        op_next     = op_reg;
        neg_q_next  = neg_q_reg;
        neg_r_next  = neg_r_reg;
        result_next = result_reg;
        stall       = 1'b0;
        done        = 1'b0;
        busy        = (state_reg != IDLE);

        case (state_reg)
            IDLE: begin
                stall = start;
                if (start) begin
                    op_next    = op;
                    neg_q_next = a_neg ^ b_neg;
                    neg_r_next = a_neg;
                    count_next = '0;
                    if (div_special) begin
                        result_next = special_res;
                        state_next  = FIN;
                    end else begin
                        opnd_next  = op[2] ? b_mag : a_mag;
                        acc_next   = {{WIDTH{1'b0}}, (op[2] ? a_mag : b_mag)};
                        state_next = CALC;
                    end
                end
            end
            CALC: begin
                stall      = 1'b1;
                acc_next   = step_acc;
                count_next = count_reg + 6'd1;
                if (count_reg == LAST) begin
                    result_next = final_res;
                    state_next  = FIN;
                end
            end
            FIN: begin
                // Suppress the pulse in a cycle where reset is being applied
                done       = rst;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase

        // Abort kills the instruction without touching the visible result
        if (flush) begin
            state_next  = IDLE;
            result_next = result_reg;
        end
    end

    // State and datapath registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg  <= IDLE;
            count_reg  <= '0;
            acc_reg    <= '0;
            opnd_reg   <= '0;
            op_reg     <= '0;
            neg_q_reg  <= 1'b0;
            neg_r_reg  <= 1'b0;
            result_reg <= '0;
        end else begin
            state_reg  <= state_next;
            count_reg  <= count_next;
            acc_reg    <= acc_next;
            opnd_reg   <= opnd_next;
            op_reg     <= op_next;
            neg_q_reg  <= neg_q_next;
            neg_r_reg  <= neg_r_next;
            result_reg <= result_next;
        end
    end

    assign result = result_reg;

endmodule

// File: tb/tb_ex_muldiv.sv
// Scoreboard testbench for ex_muldiv: expected results are queued at issue
// and popped when done is observed. Inputs change on the falling edge.
module tb_ex_muldiv;

    localparam int WIDTH    = 32;
    localparam int LAT_NORM = WIDTH + 1;  // start edge through the FIN entry edge
    localparam int LAT_SPEC = 1;

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_DIVU   = 3'b101;
    localparam logic [2:0] OP_REM    = 3'b110;
    localparam logic [2:0] OP_REMU   = 3'b111;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             start = 1'b0;
    logic             flush = 1'b0;
    logic [2:0]       op = '0;
    logic [WIDTH-1:0] src_a = '0;
    logic [WIDTH-1:0] src_b = '0;
    logic             stall;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;

    int checks   = 0;
    int failures = 0;
    logic [WIDTH-1:0] sb_q[$];

    ex_muldiv #(.WIDTH(WIDTH)) dut (
        .clk(clk), .rst(rst), .start(start), .flush(flush), .op(op),
        .src_a(src_a), .src_b(src_b), .stall(stall), .busy(busy),
        .done(done), .result(result)
    );

    always #5 clk = ~clk;

    // Reference arithmetic built on 64-bit host operators
    function automatic logic [31:0] ref_model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        longint     sa = longint'($signed(a));
        longint     sb = longint'($signed(b));
        longint     ua = longint'({32'b0, a});
        logic [63:0] p;
        logic [31:0] r;
        r = '0;
        case (o)
            OP_MUL:    begin p = 64'(sa * sb); r = p[31:0];  end
            OP_MULH:   begin p = 64'(sa * sb); r = p[63:32]; end
            OP_MULHSU: begin p = 64'(sa * longint'({32'b0, b})); r = p[63:32]; end
            OP_MULHU:  begin p = {32'b0, a} * {32'b0, b}; r = p[63:32]; end
            OP_DIV:    r = (b == 0) ? 32'hFFFF_FFFF :
                           (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? 32'h8000_0000 : 32'(sa / sb);
            OP_DIVU:   r = (b == 0) ? 32'hFFFF_FFFF : a / b;
            OP_REM:    r = (b == 0) ? a :
                           (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? 32'h0 : 32'(sa % sb);
            default:   r = (b == 0) ? a : 32'(ua % longint'({32'b0, b}));
        endcase
        return r;
    endfunction

    // Issue one operation, queue its expected result, wait (bounded) for done
    task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, output logic [31:0] got,
                          output int lat, output int stalls, output bit tmo);
        @(negedge clk);
        op = o; src_a = a; src_b = b; start = 1'b1;
        sb_q.push_back(exp);
        lat = 0; stalls = 0; tmo = 1'b0; got = '0;
        #1;
        if (stall) stalls++;
        while (1) begin
            @(negedge clk);
            lat++;
            if (stall) stalls++;
            if (done === 1'b1) begin
                got = result;
                break;
            end
            if (lat > 200) begin
                tmo = 1'b1;
                break;
            end
        end
        start = 1'b0;
        $display("op=%0d a=%h b=%h result=%h latency=%0d stall_cycles=%0d", o, a, b, got, lat, stalls);
    endtask

    task automatic test_reset();
        logic [31:0] got, exp;
        int lat, stalls;
        bit tmo;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (busy !== 1'b0)  begin failures++; $display("FAIL reset_busy got=%b want=0", busy); end
        checks++; if (stall !== 1'b0) begin failures++; $display("FAIL reset_stall got=%b want=0", stall); end
        checks++; if (done !== 1'b0)  begin failures++; $display("FAIL reset_done got=%b want=0", done); end
        checks++; if (result !== '0)  begin failures++; $display("FAIL reset_result got=%h want=0", result); end
        rst = 1'b1;

        // Give result a nonzero value so clearing by reset is visible
        run_op(OP_MUL, 32'd3, 32'd3, 32'd9, got, lat, stalls, tmo);
        exp = sb_q.pop_front();
        checks++; if (tmo || got !== exp) begin failures++; $display("FAIL pre_reset_mul got=%h want=%h tmo=%0d", got, exp, tmo); end

        // Abort a CALC at count=10 with two cycles of reset
        @(negedge clk);
        op = OP_MUL; src_a = 32'd5; src_b = 32'd5; start = 1'b1;
        repeat (11) @(negedge clk);
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL midcalc_busy got=%b want=1", busy); end
        rst = 1'b0; start = 1'b0;
        @(negedge clk);
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_cycle_done got=%b want=0", done); end
        @(negedge clk);
        rst = 1'b1;
        checks++; if (busy !== 1'b0)  begin failures++; $display("FAIL midreset_busy got=%b want=0", busy); end
        checks++; if (stall !== 1'b0) begin failures++; $display("FAIL midreset_stall got=%b want=0", stall); end
        checks++; if (done !== 1'b0)  begin failures++; $display("FAIL midreset_done got=%b want=0", done); end
        checks++; if (result !== '0)  begin failures++; $display("FAIL midreset_result got=%h want=0", result); end
    endtask

    task automatic test_mul();
        logic [2:0]  ops [5] = '{OP_MUL, OP_MULHU, OP_MULH, OP_MULHSU, OP_MUL};
        logic [31:0] as  [5] = '{32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
        logic [31:0] bs  [5] = '{32'd6, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0002, 32'd5};
        logic [31:0] es  [5] = '{32'h0000_002A, 32'hFFFF_FFFE, 32'h0000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFF1};
        logic [31:0] got, exp;
        int lat, stalls;
        bit tmo;
        for (int i = 0; i < 5; i++) begin
            run_op(ops[i], as[i], bs[i], es[i], got, lat, stalls, tmo);
            exp = sb_q.pop_front();
            checks++; if (tmo || got !== exp) begin failures++; $display("FAIL mul_%0d got=%h want=%h tmo=%0d", i, got, exp, tmo); end
            checks++; if (lat != LAT_NORM) begin failures++; $display("FAIL mul_lat_%0d got=%0d want=%0d", i, lat, LAT_NORM); end
            checks++; if (stalls != LAT_NORM) begin failures++; $display("FAIL mul_stall_%0d got=%0d want=%0d", i, stalls, LAT_NORM); end
        end
    endtask

    task automatic test_div();
        logic [2:0]  ops [4] = '{OP_DIV, OP_REM, OP_DIVU, OP_REMU};
        logic [31:0] as  [4] = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'hFFFF_FFF9};
        logic [31:0] bs  [4] = '{32'd2, 32'd2, 32'd2, 32'd2};
        logic [31:0] es  [4] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'h7FFF_FFFC, 32'h0000_0001};
        logic [31:0] got, exp;
        int lat, stalls;
        bit tmo;
        for (int i = 0; i < 4; i++) begin
            run_op(ops[i], as[i], bs[i], es[i], got, lat, stalls, tmo);
            exp = sb_q.pop_front();
            checks++; if (tmo || got !== exp) begin failures++; $display("FAIL div_%0d got=%h want=%h tmo=%0d", i, got, exp, tmo); end
            checks++; if (lat != LAT_NORM) begin failures++; $display("FAIL div_lat_%0d got=%0d want=%0d", i, lat, LAT_NORM); end
        end
    endtask

    task automatic test_special();
        logic [2:0]  ops [4] = '{OP_DIVU, OP_REM, OP_DIV, OP_REM};
        logic [31:0] as  [4] = '{32'd123, 32'd123, 32'h8000_0000, 32'h8000_0000};
        logic [31:0] bs  [4] = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [31:0] es  [4] = '{32'hFFFF_FFFF, 32'h0000_007B, 32'h8000_0000, 32'h0000_0000};
        logic [31:0] got, exp;
        int lat, stalls;
        bit tmo;
        for (int i = 0; i < 4; i++) begin
            run_op(ops[i], as[i], bs[i], es[i], got, lat, stalls, tmo);
            exp = sb_q.pop_front();
            checks++; if (tmo || got !== exp) begin failures++; $display("FAIL special_%0d got=%h want=%h tmo=%0d", i, got, exp, tmo); end
            checks++; if (lat != LAT_SPEC) begin failures++; $display("FAIL special_lat_%0d got=%0d want=%0d", i, lat, LAT_SPEC); end
            checks++; if (stalls != LAT_SPEC) begin failures++; $display("FAIL special_stall_%0d got=%0d want=%0d", i, stalls, LAT_SPEC); end
        end
    endtask

    task automatic test_flush();
        logic [31:0] got, exp;
        int lat, stalls, seen;
        bit tmo;
        run_op(OP_MUL, 32'd7, 32'd6, 32'd42, got, lat, stalls, tmo);
        exp = sb_q.pop_front();
        checks++; if (tmo || got !== exp) begin failures++; $display("FAIL preflush_mul got=%h want=%h", got, exp); end

        @(negedge clk);
        op = OP_DIVU; src_a = 32'd1000; src_b = 32'd3; start = 1'b1;
        repeat (11) @(negedge clk);
        flush = 1'b1; start = 1'b0;
        @(negedge clk);
        flush = 1'b0;
        checks++; if (busy !== 1'b0)  begin failures++; $display("FAIL flush_busy got=%b want=0", busy); end
        checks++; if (stall !== 1'b0) begin failures++; $display("FAIL flush_stall got=%b want=0", stall); end
        checks++; if (result !== 32'd42) begin failures++; $display("FAIL flush_result got=%h want=%h", result, 32'd42); end
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) seen++;
        end
        checks++; if (seen != 0) begin failures++; $display("FAIL flush_no_done got=%0d want=0", seen); end
        $display("flush at count=10: busy=%b result=%h done_pulses=%0d", busy, result, seen);

        run_op(OP_DIVU, 32'd100, 32'd7, 32'h0000_000E, got, lat, stalls, tmo);
        exp = sb_q.pop_front();
        checks++; if (tmo || got !== exp) begin failures++; $display("FAIL postflush_divu got=%h want=%h tmo=%0d", got, exp, tmo); end
    endtask

    task automatic test_hold_start();
        logic [31:0] got, exp;
        int lat;
        @(negedge clk);
        op = OP_MUL; src_a = 32'd11; src_b = 32'd13; start = 1'b1;
        sb_q.push_back(32'd143);
        lat = 0; got = '0;
        while (lat <= 200) begin
            @(negedge clk);
            lat++;
            if (done === 1'b1) begin
                got = result;
                break;
            end
            src_a = $urandom;
            src_b = $urandom;
        end
        start = 1'b0;
        $display("op=%0d a=%h b=%h result=%h latency=%0d (operands churned)", OP_MUL, 32'd11, 32'd13, got, lat);
        exp = sb_q.pop_front();
        checks++; if (got !== exp) begin failures++; $display("FAIL hold_start got=%h want=%h", got, exp); end
        checks++; if (lat != LAT_NORM) begin failures++; $display("FAIL hold_start_lat got=%0d want=%0d", lat, LAT_NORM); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] got, exp;
        int lat, stalls;
        bit tmo;
        run_op(OP_MUL, 32'd100, 32'd200, 32'd20000, got, lat, stalls, tmo);
        exp = sb_q.pop_front();
        checks++; if (tmo || got !== exp) begin failures++; $display("FAIL b2b_first got=%h want=%h", got, exp); end
        run_op(OP_MUL, 32'd12345, 32'd678, 32'd8369910, got, lat, stalls, tmo);
        exp = sb_q.pop_front();
        checks++; if (tmo || got !== exp) begin failures++; $display("FAIL b2b_second got=%h want=%h", got, exp); end
        checks++; if (lat != LAT_NORM) begin failures++; $display("FAIL b2b_lat got=%0d want=%0d", lat, LAT_NORM); end
    endtask

    task automatic test_random();
        logic [31:0] got, exp, a, b;
        logic [2:0]  o;
        int lat, stalls;
        bit tmo;
        for (int i = 0; i < 16; i++) begin
            o = 3'($urandom_range(0, 7));
            a = $urandom;
            b = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
            if (i % 3 == 1) b = 32'($urandom_range(1, 50));
            run_op(o, a, b, ref_model(o, a, b), got, lat, stalls, tmo);
            exp = sb_q.pop_front();
            checks++; if (tmo || got !== exp) begin failures++; $display("FAIL random_%0d op=%0d got=%h want=%h", i, o, got, exp); end
        end
    endtask

    initial begin
        test_reset();
        test_mul();
        test_div();
        test_special();
        test_flush();
        test_hold_start();
        test_back_to_back();
        test_random();
        checks++; if (sb_q.size() != 0) begin failures++; $display("FAIL scoreboard_empty got=%0d want=0", sb_q.size()); end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global time limit in case a wait escapes its own bound
    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
